nasti_txn_scheduler: RTL and testbench
======================================

// Module: nasti_txn_scheduler
// PURPOSE
//  Core-clock stage downstream of the NASTI frontend async FIFOs. Arbitrates AR vs AW, expands each burst into
//  per-beat DDR commands (pairing W beats with writes), returns read beats into the R FIFO in order using a tag
//  queue, and pushes one B response per write burst. Feeds the DDR command/bank logic.
// PARAMETERS
//  C_NASTI_ADDR_WIDTH  16  byte address width (cmd_addr)
//  C_NASTI_DATA_WIDTH  64  beat width; strobe width = C_NASTI_DATA_WIDTH/8
//  C_TAG_DEPTH         8   max outstanding read beats (power of 2)
// PORTS
//  core_clk   in   1      core clock
//  core_arst  in   1      asynchronous reset, active-high
//  rdata_ar / rempty_ar / rinc_ar   in/in/out  ar_trans/1/1   AR FIFO read side
//  rdata_aw / rempty_aw / rinc_aw   in/in/out  aw_trans/1/1   AW FIFO read side
//  rdata_w  / rempty_w  / rinc_w    in/in/out  w_trans/1/1    W FIFO read side
//  wdata_r  / wfull_r   / winc_r    out/in/out r_trans/1/1    R FIFO write side
//  wdata_b  / wfull_b   / winc_b    out/in/out b_trans/1/1    B FIFO write side
//  cmd_valid/cmd_ready  out/in 1    beat command handshake to DDR backend
//  cmd_we     out  1      1=write beat, 0=read beat
//  cmd_addr   out  ADDR   beat byte address
//  cmd_wdata  out  DATA   write data (= rdata_w.w_data while cmd_we)
//  cmd_wstrb  out  DATA/8 write strobes
//  rd_valid/rd_ready in/out 1  in-order read return; rd_ready = ~wfull_r & ~tag_empty
//  rd_data    in   DATA   read beat data
// BEHAVIOUR
//  Reset: state=IDLE, all rinc_*/winc_*/cmd_valid=0, prio=READ, tag queue empty, beat counters 0.
//  FSM IDLE -> RD_BURST | WR_BURST -> (WR_RESP) -> IDLE.
//  IDLE: if ~rempty_ar and (prio=READ or rempty_aw): pulse rinc_ar, latch id/addr/len/size/burst/user, go RD_BURST.
//   Else if ~rempty_aw: pulse rinc_aw, latch, go WR_BURST. prio flips to the other side on every burst completion.
//  RD_BURST: cmd_valid=~tag_full; on cmd_valid&cmd_ready push tag {id, last=(beat==len), user}, advance addr/beat;
//   after beat==len accepted -> IDLE. First cmd_valid one cycle after rinc_ar.
//  WR_BURST: cmd_valid=~rempty_w, cmd_we=1; rinc_w = cmd_valid&cmd_ready (pop same cycle as accept).
//   Beat counter governs burst end; w_last != (beat==len) on any beat sets err flag. After last beat -> WR_RESP.
//  WR_RESP: winc_b=~wfull_b, wdata_b={id, err?2'b10:2'b00, user}; on push clear err, -> IDLE. Holds while wfull_b.
//  Address: FIXED(00) constant; INCR(01, also RSVD 11) addr += 1<<size;
//   WRAP(10): boundary = (len+1)<<size, low bits wrap modulo boundary, upper bits kept. Arithmetic at ADDR width, no carry out.
//  Return: rd_valid&rd_ready -> winc_r=1, wdata_r={tag.id, rd_data, tag.last, 2'b00, tag.user}, pop tag.
//   Return path runs concurrently with FSM; tag push and pop in same cycle keep count unchanged.
//  rd_valid with tag queue empty is a backend protocol error (assertion); rd_ready held 0.
//  tag_full stalls read issue only; never drops data. Write path never touches the tag queue.
//  Reset mid-burst: burst abandoned, queue flushed; frontend FIFOs not reset here.
// STRUCTURE
//  Package nasti_pkg: ar_trans/aw_trans/w_trans/r_trans/b_trans structs, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR.
//  Sub-module sync_fifo (params width, depth) for the tag queue; address generator is a function in the package.
// TESTING
//  AR{id=5,addr=0x100,len=3,size=3,INCR}, cmd_ready=1 -> read cmds at 0x100,0x108,0x110,0x118; 4 R pushes id=5, last on 4th only.
//  AR WRAP len=3 size=3 addr=0x118 -> addrs 0x118,0x100,0x108,0x110.
//  AW{id=2,len=1} + W beats (last on 2nd) -> 2 write cmds with W data/strb, then B{id=2,resp=00}; wfull_b held 5 cycles -> winc_b waits.
//  AW len=1 with w_last on beat 0 -> 2 write cmds, B resp=2'b10.
//  AR and AW both pending from reset -> read burst first, then write, then read (alternation).
//  C_TAG_DEPTH=8, rd_valid=0, AR len=15 -> exactly 8 read cmds then stall; rd returns resume issue; assert core_arst mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/nasti_pkg.sv
// Shared NASTI transaction types, burst/response encodings and the per-beat
// address generator used by the core-clock transaction scheduler.
package nasti_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = 4;
    localparam int USER_W = 2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [USER_W-1:0] user;
    } ar_trans;

    typedef ar_trans aw_trans;

    typedef struct packed {
        logic [DATA_W-1:0] w_data;
        logic [STRB_W-1:0] w_strb;
        logic              w_last;
    } w_trans;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic              last;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } r_trans;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_trans;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              last;
        logic [USER_W-1:0] user;
    } tag_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RD_BURST, ST_WR_BURST, ST_WR_RESP} state_e;
    typedef enum logic {PRIO_READ, PRIO_WRITE} prio_e;

    // Address of the beat following addr; WRAP keeps the bits above the
    // (len+1)<<size boundary and wraps the low bits inside it.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0]        len,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] incr;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        incr = addr + step;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
            default:     next_addr = incr;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/nasti_txn_scheduler.sv
// Core-clock NASTI scheduler: arbitrates AR/AW, expands bursts into beat
// commands, returns read beats in order via a tag queue, emits one B per write.
module nasti_txn_scheduler
    import nasti_pkg::*;
#(
    parameter int C_NASTI_ADDR_WIDTH = ADDR_W,
    parameter int C_NASTI_DATA_WIDTH = DATA_W,
    parameter int C_TAG_DEPTH        = 8
) (
    input  logic                            core_clk,
    input  logic                            core_arst,
    input  ar_trans                         rdata_ar,
    input  logic                            rempty_ar,
    output logic                            rinc_ar,
    input  aw_trans                         rdata_aw,
    input  logic                            rempty_aw,
    output logic                            rinc_aw,
    input  w_trans                          rdata_w,
    input  logic                            rempty_w,
    output logic                            rinc_w,
    output r_trans                          wdata_r,
    input  logic                            wfull_r,
    output logic                            winc_r,
    output b_trans                          wdata_b,
    input  logic                            wfull_b,
    output logic                            winc_b,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic                            cmd_we,
    output logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr,
    output logic [C_NASTI_DATA_WIDTH-1:0]   cmd_wdata,
    output logic [C_NASTI_DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic                            rd_valid,
    output logic                            rd_ready,
    input  logic [C_NASTI_DATA_WIDTH-1:0]   rd_data
);
    state_e     state, nxt_state;
    prio_e      prio;
    ar_trans    cur;
    logic [7:0] beat;
    logic       err;
    logic       tag_full, tag_empty, tag_push;
    tag_t       tag_in, tag_head;
    logic       take_ar, take_aw, cmd_fire, beat_last;

    assign take_ar   = !rempty_ar && (prio == PRIO_READ || rempty_aw);
    assign take_aw   = !rempty_aw && !take_ar;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_last = (beat == cur.len);

    always_ff @(posedge core_clk or posedge core_arst) begin
        if (core_arst) state <= ST_IDLE;
        else           state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE:     if (take_ar) nxt_state = ST_RD_BURST;
                         else if (take_aw) nxt_state = ST_WR_BURST;
            ST_RD_BURST: if (cmd_fire && beat_last) nxt_state = ST_IDLE;
            ST_WR_BURST: if (cmd_fire && beat_last) nxt_state = ST_WR_RESP;
            ST_WR_RESP:  if (!wfull_b) nxt_state = ST_IDLE;
            default:     nxt_state = ST_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        rinc_ar   = 1'b0;
        rinc_aw   = 1'b0;
        rinc_w    = 1'b0;
        winc_b    = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        if (!core_arst) begin
            case (state)
                ST_IDLE: begin
                    rinc_ar = take_ar;
                    rinc_aw = take_aw;
                end
                ST_RD_BURST: cmd_valid = !tag_full;
                ST_WR_BURST: begin
                    cmd_valid = !rempty_w;
                    cmd_we    = 1'b1;
                    cmd_wdata = rdata_w.w_data;
                    cmd_wstrb = rdata_w.w_strb;
                    rinc_w    = !rempty_w && cmd_ready;
                end
                ST_WR_RESP: winc_b = !wfull_b;
                default: ;
            endcase
        end
    end

    assign cmd_addr = cur.addr;
    assign wdata_b  = '{id: cur.id, resp: (err ? RESP_SLVERR : RESP_OKAY), user: cur.user};

    always_ff @(posedge core_clk or posedge core_arst) begin
        if (core_arst) begin
            cur  <= '0;
            beat <= '0;
            err  <= 1'b0;
            prio <= PRIO_READ;
        end else begin
            if (rinc_ar)
                cur <= rdata_ar;
            else if (rinc_aw)
                cur <= rdata_aw;
            if (cmd_fire) begin
                beat     <= beat_last ? 8'd0 : beat + 8'd1;
                cur.addr <= next_addr(cur.addr, cur.len, cur.size, cur.burst);
            end
            // Beat count, not w_last, ends the burst; a disagreement is reported in B.
            if (state == ST_WR_BURST && cmd_fire && (rdata_w.w_last != beat_last))
                err <= 1'b1;
            if (winc_b)
                err <= 1'b0;
            if ((state == ST_RD_BURST && cmd_fire && beat_last) || winc_b)
                prio <= (prio == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
        end
    end

    assign tag_push = (state == ST_RD_BURST) && cmd_fire;
    assign tag_in   = '{id: cur.id, last: beat_last, user: cur.user};

    sync_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (C_TAG_DEPTH)
    ) u_tag_q (
        .clk   (core_clk),
        .rst   (core_arst),
        .push  (tag_push),
        .wdata (tag_in),
        .pop   (winc_r),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign rd_ready = !wfull_r && !tag_empty;
    assign winc_r   = rd_valid && rd_ready;

    always_comb begin
        wdata_r      = '0;
        wdata_r.id   = tag_head.id;
        wdata_r.data = rd_data;
        wdata_r.last = tag_head.last;
        wdata_r.resp = RESP_OKAY;
        wdata_r.user = tag_head.user;
    end

    rd_valid_needs_tag: assert property (@(posedge core_clk) disable iff (core_arst)
                                         !(rd_valid && tag_empty));

endmodule

// File: tb/tb_nasti_txn_scheduler.sv
// Directed bench: queue-modelled frontend FIFOs and read backend around the
// scheduler, with hand-computed expected commands, R beats and B responses.
module tb_nasti_txn_scheduler;
    import nasti_pkg::*;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } cmd_t;

    logic        core_clk  = 1'b0;
    logic        core_arst = 1'b1;
    ar_trans     rdata_ar  = '0;
    logic        rempty_ar = 1'b1;
    logic        rinc_ar;
    aw_trans     rdata_aw  = '0;
    logic        rempty_aw = 1'b1;
    logic        rinc_aw;
    w_trans      rdata_w   = '0;
    logic        rempty_w  = 1'b1;
    logic        rinc_w;
    r_trans      wdata_r;
    logic        wfull_r   = 1'b0;
    logic        winc_r;
    b_trans      wdata_b;
    logic        wfull_b   = 1'b0;
    logic        winc_b;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic        rd_valid  = 1'b0;
    logic        rd_ready;
    logic [63:0] rd_data   = '0;

    cmd_t        cmd_log[$];
    r_trans      r_log[$];
    b_trans      b_log[$];
    ar_trans     ar_q[$];
    aw_trans     aw_q[$];
    w_trans      w_q[$];
    logic [15:0] rdq[$];
    logic        pop_ar = 1'b0, pop_aw = 1'b0, pop_w = 1'b0, pop_rd = 1'b0;
    logic        rd_en  = 1'b0;
    int          tests  = 0;
    int          fails  = 0;

    nasti_txn_scheduler dut (
        .core_clk  (core_clk),
        .core_arst (core_arst),
        .rdata_ar  (rdata_ar),
        .rempty_ar (rempty_ar),
        .rinc_ar   (rinc_ar),
        .rdata_aw  (rdata_aw),
        .rempty_aw (rempty_aw),
        .rinc_aw   (rinc_aw),
        .rdata_w   (rdata_w),
        .rempty_w  (rempty_w),
        .rinc_w    (rinc_w),
        .wdata_r   (wdata_r),
        .wfull_r   (wfull_r),
        .winc_r    (winc_r),
        .wdata_b   (wdata_b),
        .wfull_b   (wfull_b),
        .winc_b    (winc_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data)
    );

    always #5 core_clk = ~core_clk;

    // Handshakes are stable at the falling edge and complete at the next rising edge.
    always @(negedge core_clk) begin
        pop_ar = rinc_ar;
        pop_aw = rinc_aw;
        pop_w  = rinc_w;
        pop_rd = rd_valid && rd_ready;
        if (cmd_valid && cmd_ready) begin
            cmd_log.push_back(cmd_t'{cmd_we, cmd_addr, cmd_wdata, cmd_wstrb});
            if (!cmd_we)
                rdq.push_back(cmd_addr);
        end
        if (winc_r) r_log.push_back(wdata_r);
        if (winc_b) b_log.push_back(wdata_b);
    end

    // Frontend FIFO and read backend models: pop after the edge, present new heads later.
    always @(posedge core_clk) begin
        #1;
        if (pop_ar && ar_q.size() > 0) void'(ar_q.pop_front());
        if (pop_aw && aw_q.size() > 0) void'(aw_q.pop_front());
        if (pop_w  && w_q.size()  > 0) void'(w_q.pop_front());
        if (pop_rd && rdq.size()  > 0) void'(rdq.pop_front());
        #2;
        rempty_ar = (ar_q.size() == 0);
        if (!rempty_ar) rdata_ar = ar_q[0];
        rempty_aw = (aw_q.size() == 0);
        if (!rempty_aw) rdata_aw = aw_q[0];
        rempty_w  = (w_q.size() == 0);
        if (!rempty_w) rdata_w = w_q[0];
        rd_valid  = rd_en && (rdq.size() > 0);
        rd_data   = rd_valid ? {16'hDA7A, 32'h0, rdq[0]} : 64'h0;
    end

    task automatic tick();
        @(posedge core_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_logs(input int ncmd, input int nr, input int nb, input int budget);
        int k = 0;
        while ((cmd_log.size() < ncmd || r_log.size() < nr || b_log.size() < nb) && k < budget) begin
            tick();
            k++;
        end
        repeat (4) tick();
        chk("cmd_count", 128'(cmd_log.size()), 128'(ncmd));
        chk("r_count",   128'(r_log.size()),   128'(nr));
        chk("b_count",   128'(b_log.size()),   128'(nb));
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        r_log.delete();
        b_log.delete();
    endtask

    function automatic ar_trans mk_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                                      input logic [1:0] burst, input logic [1:0] user);
        mk_ar = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst, user: user};
    endfunction

    function automatic r_trans exp_r(input logic [3:0] id, input logic [15:0] addr,
                                     input logic last, input logic [1:0] user);
        exp_r = '{id: id, data: {16'hDA7A, 32'h0, addr}, last: last, resp: RESP_OKAY, user: user};
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_valid"}, 128'(cmd_valid), 128'(0));
        chk({tag, "_rinc_ar"},   128'(rinc_ar),   128'(0));
        chk({tag, "_rinc_aw"},   128'(rinc_aw),   128'(0));
        chk({tag, "_rinc_w"},    128'(rinc_w),    128'(0));
        chk({tag, "_winc_r"},    128'(winc_r),    128'(0));
        chk({tag, "_winc_b"},    128'(winc_b),    128'(0));
        chk({tag, "_rd_ready"},  128'(rd_ready),  128'(0));
        chk({tag, "_cmd_addr"},  128'(cmd_addr),  128'(0));
    endtask

    initial begin
        logic [15:0] wrap_addr [4];
        wrap_addr = '{16'h118, 16'h100, 16'h108, 16'h110};

        // Reset: AR already pending must not be popped while reset is held.
        ar_q.push_back(mk_ar(4'd5, 16'h100, 8'd3, BURST_INCR, 2'd1));
        repeat (3) tick();
        chk_idle_outputs("reset");

        // INCR read burst with in-order returns.
        core_arst = 1'b0;
        cmd_ready = 1'b1;
        rd_en     = 1'b1;
        wait_logs(4, 4, 0, 100);
        for (int i = 0; i < 4 && i < cmd_log.size() && i < r_log.size(); i++) begin
            chk("incr_cmd", cmd_log[i], cmd_t'{1'b0, 16'h100 + 16'(8 * i), 64'h0, 8'h0});
            chk("incr_r", r_log[i], exp_r(4'd5, 16'h100 + 16'(8 * i), (i == 3), 2'd1));
        end

        // WRAP read burst.
        clear_logs();
        ar_q.push_back(mk_ar(4'd3, 16'h118, 8'd3, BURST_WRAP, 2'd0));
        wait_logs(4, 4, 0, 100);
        for (int i = 0; i < 4 && i < cmd_log.size() && i < r_log.size(); i++) begin
            chk("wrap_cmd", cmd_log[i], cmd_t'{1'b0, wrap_addr[i], 64'h0, 8'h0});
            chk("wrap_r", r_log[i], exp_r(4'd3, wrap_addr[i], (i == 3), 2'd0));
        end

        // Write burst, B held off by wfull_b.
        clear_logs();
        wfull_b = 1'b1;
        aw_q.push_back(mk_ar(4'd2, 16'h200, 8'd1, BURST_INCR, 2'd2));
        w_q.push_back('{w_data: 64'h1111_2222_3333_4444, w_strb: 8'hFF, w_last: 1'b0});
        w_q.push_back('{w_data: 64'h5555_6666_7777_8888, w_strb: 8'h0F, w_last: 1'b1});
        wait_logs(2, 0, 0, 100);
        if (cmd_log.size() >= 2) begin
            chk("wr_cmd0", cmd_log[0], cmd_t'{1'b1, 16'h200, 64'h1111_2222_3333_4444, 8'hFF});
            chk("wr_cmd1", cmd_log[1], cmd_t'{1'b1, 16'h208, 64'h5555_6666_7777_8888, 8'h0F});
        end
        for (int i = 0; i < 5; i++) begin
            chk("b_hold", 128'(winc_b), 128'(0));
            tick();
        end
        wfull_b = 1'b0;
        wait_logs(2, 0, 1, 50);
        if (b_log.size() >= 1)
            chk("b_okay", b_log[0], b_trans'{4'd2, RESP_OKAY, 2'd2});

        // w_last on the wrong beat reports SLVERR.
        clear_logs();
        aw_q.push_back(mk_ar(4'd1, 16'h300, 8'd1, BURST_INCR, 2'd0));
        w_q.push_back('{w_data: 64'hAAAA, w_strb: 8'hFF, w_last: 1'b1});
        w_q.push_back('{w_data: 64'hBBBB, w_strb: 8'hFF, w_last: 1'b0});
        wait_logs(2, 0, 1, 100);
        if (cmd_log.size() >= 2 && b_log.size() >= 1) begin
            chk("err_cmd1", cmd_log[1], cmd_t'{1'b1, 16'h308, 64'hBBBB, 8'hFF});
            chk("b_slverr", b_log[0], b_trans'{4'd1, RESP_SLVERR, 2'd0});
        end

        // AR and AW pending from reset: read, write, read.
        core_arst = 1'b1;
        tick();
        clear_logs();
        ar_q.push_back(mk_ar(4'd6, 16'h400, 8'd0, BURST_INCR, 2'd0));
        ar_q.push_back(mk_ar(4'd8, 16'h600, 8'd0, BURST_INCR, 2'd0));
        aw_q.push_back(mk_ar(4'd7, 16'h500, 8'd0, BURST_INCR, 2'd1));
        w_q.push_back('{w_data: 64'hCCCC, w_strb: 8'hFF, w_last: 1'b1});
        repeat (2) tick();
        core_arst = 1'b0;
        wait_logs(3, 2, 1, 100);
        if (cmd_log.size() >= 3 && r_log.size() >= 2 && b_log.size() >= 1) begin
            chk("alt_cmd0", cmd_log[0], cmd_t'{1'b0, 16'h400, 64'h0, 8'h0});
            chk("alt_cmd1", cmd_log[1], cmd_t'{1'b1, 16'h500, 64'hCCCC, 8'hFF});
            chk("alt_cmd2", cmd_log[2], cmd_t'{1'b0, 16'h600, 64'h0, 8'h0});
            chk("alt_r1", r_log[1], exp_r(4'd8, 16'h600, 1'b1, 2'd0));
            chk("alt_b", b_log[0], b_trans'{4'd7, RESP_OKAY, 2'd1});
        end

        // Tag queue full stalls issue until returns drain it.
        clear_logs();
        rd_en = 1'b0;
        ar_q.push_back(mk_ar(4'd9, 16'h800, 8'd15, BURST_INCR, 2'd3));
        repeat (30) tick();
        chk("tag_stall_cmds", 128'(cmd_log.size()), 128'(8));
        chk("tag_stall_valid", 128'(cmd_valid), 128'(0));
        chk("tag_stall_r", 128'(r_log.size()), 128'(0));
        rd_en = 1'b1;
        wait_logs(16, 16, 0, 200);
        if (cmd_log.size() >= 16 && r_log.size() >= 16) begin
            chk("tag_cmd15", cmd_log[15], cmd_t'{1'b0, 16'h878, 64'h0, 8'h0});
            chk("tag_r14", r_log[14], exp_r(4'd9, 16'h870, 1'b0, 2'd3));
            chk("tag_r15", r_log[15], exp_r(4'd9, 16'h878, 1'b1, 2'd3));
        end

        // Reset mid-burst flushes the burst and the tag queue.
        clear_logs();
        rd_en = 1'b0;
        ar_q.push_back(mk_ar(4'd10, 16'h900, 8'd15, BURST_INCR, 2'd0));
        repeat (6) tick();
        chk("mid_valid_before", 128'(cmd_valid), 128'(1));
        core_arst = 1'b1;
        rdq.delete();
        tick();
        chk_idle_outputs("mid_reset");
        core_arst = 1'b0;
        tick();
        chk("post_reset_valid", 128'(cmd_valid), 128'(0));
        chk("post_reset_rd_ready", 128'(rd_ready), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
